// File: rtl/jtag_reg_pkg.sv
// jtag_reg_pkg: shared definitions for the JTAG register-access controller.
// Holds the command frame layout, op encodings, status bit indices and
// the controller state encoding, plus small frame field accessors.
package jtag_reg_pkg;

    localparam int unsigned FRAME_W  = 14;
    localparam int unsigned DATA_W   = 8;
    localparam int unsigned ADDR_W   = 4;
    localparam int unsigned OP_W     = 2;

    // Frame layout: {op[13:12], addr[11:8], data[7:0]}
    localparam int unsigned OP_LSB   = 12;
    localparam int unsigned ADDR_LSB = 8;
    localparam int unsigned DATA_LSB = 0;

    // status = {overrun, timeout_err, busy}
    localparam int unsigned ST_BUSY    = 0;
    localparam int unsigned ST_TIMEOUT = 1;
    localparam int unsigned ST_OVERRUN = 2;
    localparam int unsigned ST_W       = 3;

    typedef enum logic [OP_W-1:0] {
        OP_NOP       = 2'b00,
        OP_WRITE     = 2'b01,
        OP_READ      = 2'b10,
        OP_WRITE_INC = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_REQ  = 2'b01,
        S_WAIT = 2'b10
    } state_e;

    function automatic op_e frame_op(input logic [FRAME_W-1:0] f);
        return op_e'(f[OP_LSB +: OP_W]);
    endfunction

    function automatic logic [ADDR_W-1:0] frame_addr(input logic [FRAME_W-1:0] f);
        return f[ADDR_LSB +: ADDR_W];
    endfunction

    function automatic logic [DATA_W-1:0] frame_data(input logic [FRAME_W-1:0] f);
        return f[DATA_LSB +: DATA_W];
    endfunction

endpackage

// File: rtl/jtag_shift_chain.sv
// jtag_shift_chain: generic JTAG data-register chain, LSB first.
// Ports:
//   clk_i/rstn_i   JTAG clock, async active-low reset
//   tdi_i          serial in, enters at bit WIDTH-1
//   capture_i      load capture_val_i into the register
//   shift_i        shift one bit (takes priority over capture)
//   capture_val_i  parallel capture value
//   tdo_o          registered serial out (bit0 before the shift)
//   data_o         current register contents
module jtag_shift_chain #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             tdi_i,
    input  logic             capture_i,
    input  logic             shift_i,
    input  logic [WIDTH-1:0] capture_val_i,
    output logic             tdo_o,
    output logic [WIDTH-1:0] data_o
);

    logic [WIDTH-1:0] sr_q;
    logic             tdo_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sr_q  <= '0;
            tdo_q <= 1'b0;
        end else if (shift_i) begin
            tdo_q <= sr_q[0];
            sr_q  <= {tdi_i, sr_q[WIDTH-1:1]};
        end else if (capture_i) begin
            sr_q  <= capture_val_i;
        end
    end

    assign tdo_o  = tdo_q;
    assign data_o = sr_q;

endmodule

// File: rtl/jtag_reg_ctrl.sv
// jtag_reg_ctrl: JTAG-driven configuration register access controller.
// Chain 1 (14 bit) carries command frames {op, addr, data}; chain 2 (8 bit)
// returns the last read data. An update on the command chain starts one
// register access on the cfg_* handshake, bounded by TIMEOUT cycles.
// Ports:
//   JTCK, JRSTN            clock, async active-low reset
//   JTDI, JSHIFT, JUPDATE  TAP serial data / shift-DR / update-DR
//   JCE1, JCE2, JRTI1      chain enables, run-test-idle on chain 1
//   JTDO1, JTDO2           serial outputs of chain 1 / chain 2
//   cfg_req/we/addr/wdata  access request towards register slave
//   cfg_ack, cfg_rdata     access completion and read data
//   status                 {overrun, timeout_err, busy}
module jtag_reg_ctrl
    import jtag_reg_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned NREG    = 16
) (
    input  logic              JTCK,
    input  logic              JRSTN,
    input  logic              JTDI,
    input  logic              JSHIFT,
    input  logic              JUPDATE,
    input  logic              JCE1,
    input  logic              JCE2,
    input  logic              JRTI1,
    output logic              JTDO1,
    output logic              JTDO2,
    output logic              cfg_req,
    output logic              cfg_we,
    output logic [ADDR_W-1:0] cfg_addr,
    output logic [DATA_W-1:0] cfg_wdata,
    input  logic              cfg_ack,
    input  logic [DATA_W-1:0] cfg_rdata,
    output logic [ST_W-1:0]   status
);

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_e              state_q, state_d;
    op_e                 op_q, op_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   inc_addr_q, inc_addr_d;
    logic                inc_valid_q, inc_valid_d;
    logic                overrun_q, overrun_d;
    logic                tout_q, tout_d;
    logic                sel_q;

    logic [FRAME_W-1:0]  ch1_data;
    logic [DATA_W-1:0]   ch2_unused;
    logic [FRAME_W-1:0]  ch1_cap;
    logic [ADDR_W-1:0]   f_addr;
    logic [DATA_W-1:0]   f_data;
    logic [ADDR_W-1:0]   acc_addr;
    op_e                 f_op;
    logic                busy;
    logic                upd_cmd;

    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
        return (a == ADDR_W'(NREG - 1)) ? '0 : a + 1'b1;
    endfunction

    assign busy    = (state_q != S_IDLE);
    assign status  = {overrun_q, tout_q, busy};
    assign ch1_cap = {status[1:0], busy, 3'b000, rdata_q};

    jtag_shift_chain #(.WIDTH(FRAME_W)) u_chain1 (
        .clk_i         (JTCK),
        .rstn_i        (JRSTN),
        .tdi_i         (JTDI),
        .capture_i     (JCE1 & ~JSHIFT),
        .shift_i       (JCE1 & JSHIFT),
        .capture_val_i (ch1_cap),
        .tdo_o         (JTDO1),
        .data_o        (ch1_data)
    );

    jtag_shift_chain #(.WIDTH(DATA_W)) u_chain2 (
        .clk_i         (JTCK),
        .rstn_i        (JRSTN),
        .tdi_i         (JTDI),
        .capture_i     (JCE2 & ~JSHIFT),
        .shift_i       (JCE2 & JSHIFT),
        .capture_val_i (rdata_q),
        .tdo_o         (JTDO2),
        .data_o        (ch2_unused)
    );

    assign f_op   = frame_op(ch1_data);
    assign f_addr = frame_addr(ch1_data);
    assign f_data = frame_data(ch1_data);

    // JUPDATE is shared by both chains; only the command chain acts on it.
    assign upd_cmd = JUPDATE && sel_q && (f_op != OP_NOP);

    // Auto-increment frames reuse the running address once a sequence has begun.
    assign acc_addr = (f_op == OP_WRITE_INC && inc_valid_q) ? inc_addr_q : f_addr;

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        cnt_d       = cnt_q;
        inc_addr_d  = inc_addr_q;
        inc_valid_d = inc_valid_q;
        overrun_d   = overrun_q;
        tout_d      = tout_q;
        case (state_q)
            S_IDLE: begin
                if (JRTI1) begin
                    overrun_d = 1'b0;
                    tout_d    = 1'b0;
                end
                if (upd_cmd) begin
                    state_d = S_REQ;
                    op_d    = f_op;
                    addr_d  = acc_addr;
                    wdata_d = f_data;
                    cnt_d   = '0;
                    if (f_op == OP_WRITE_INC) begin
                        inc_addr_d  = acc_addr;
                        inc_valid_d = 1'b1;
                    end else begin
                        inc_valid_d = 1'b0;
                    end
                end
            end
            S_REQ, S_WAIT: begin
                if (upd_cmd) begin
                    overrun_d = 1'b1;
                end
                if (cfg_ack) begin
                    state_d = S_IDLE;
                    if (op_q == OP_READ) begin
                        rdata_d = cfg_rdata;
                    end
                    if (op_q == OP_WRITE_INC) begin
                        inc_addr_d = next_addr(addr_q);
                    end
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    // Timed out: leave rdata_q and the running address as they are.
                    state_d = S_IDLE;
                    tout_d  = 1'b1;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = S_WAIT;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge JTCK or negedge JRSTN) begin
        if (!JRSTN) begin
            state_q     <= S_IDLE;
            op_q        <= OP_NOP;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            cnt_q       <= '0;
            inc_addr_q  <= '0;
            inc_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            tout_q      <= 1'b0;
            sel_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            cnt_q       <= cnt_d;
            inc_addr_q  <= inc_addr_d;
            inc_valid_q <= inc_valid_d;
            overrun_q   <= overrun_d;
            tout_q      <= tout_d;
            if (JCE1) begin
                sel_q <= 1'b1;
            end else if (JCE2) begin
                sel_q <= 1'b0;
            end
        end
    end

    // Request is decoded from the state register so reset removes it at once.
    assign cfg_req   = busy;
    assign cfg_we    = (op_q == OP_WRITE) || (op_q == OP_WRITE_INC);
    assign cfg_addr  = addr_q;
    assign cfg_wdata = wdata_q;

endmodule

// File: tb/tb_jtag_reg_ctrl.sv
// tb_jtag_reg_ctrl: directed self-checking bench for jtag_reg_ctrl.
module tb_jtag_reg_ctrl;

    logic       JTCK = 1'b0;
    logic       JRSTN = 1'b1;
    logic       JTDI = 1'b0;
    logic       JSHIFT = 1'b0;
    logic       JUPDATE = 1'b0;
    logic       JCE1 = 1'b0;
    logic       JCE2 = 1'b0;
    logic       JRTI1 = 1'b0;
    logic       JTDO1, JTDO2;
    logic       cfg_req, cfg_we;
    logic [3:0] cfg_addr;
    logic [7:0] cfg_wdata;
    logic       cfg_ack = 1'b0;
    logic [7:0] cfg_rdata = 8'h00;
    logic [2:0] status;

    int checks = 0;
    int failures = 0;

    jtag_reg_ctrl #(.TIMEOUT(255), .NREG(16)) dut (
        .JTCK      (JTCK),
        .JRSTN     (JRSTN),
        .JTDI      (JTDI),
        .JSHIFT    (JSHIFT),
        .JUPDATE   (JUPDATE),
        .JCE1      (JCE1),
        .JCE2      (JCE2),
        .JRTI1     (JRTI1),
        .JTDO1     (JTDO1),
        .JTDO2     (JTDO2),
        .cfg_req   (cfg_req),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .cfg_ack   (cfg_ack),
        .cfg_rdata (cfg_rdata),
        .status    (status)
    );

    always #5 JTCK = ~JTCK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic shift_frame(input logic [13:0] f);
        JCE1 = 1'b1;
        JSHIFT = 1'b1;
        for (int i = 0; i < 14; i++) begin
            JTDI = f[i];
            @(negedge JTCK);
        end
        JCE1 = 1'b0;
        JSHIFT = 1'b0;
        JTDI = 1'b0;
    endtask

    task automatic update();
        JUPDATE = 1'b1;
        @(negedge JTCK);
        JUPDATE = 1'b0;
    endtask

    // Capture then shift out n bits of chain 1 (two=0) or chain 2 (two=1).
    task automatic read_chain(input bit two, input int n, output logic [13:0] v);
        v = '0;
        if (two) JCE2 = 1'b1; else JCE1 = 1'b1;
        JSHIFT = 1'b0;
        @(negedge JTCK);
        JSHIFT = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge JTCK);
            v[i] = two ? JTDO2 : JTDO1;
        end
        JCE1 = 1'b0;
        JCE2 = 1'b0;
        JSHIFT = 1'b0;
    endtask

    // Slave model: acks on the (delay+1)-th request cycle; counts request cycles.
    task automatic slave(input int delay, input logic [7:0] rd, input int maxc,
                         output int cyc, output logic we, output logic [3:0] a,
                         output logic [7:0] wd);
        cyc = 0; we = 1'b0; a = '0; wd = '0;
        while (cfg_req === 1'b1 && cyc < maxc) begin
            cyc++;
            if (cyc == 1) begin
                we = cfg_we; a = cfg_addr; wd = cfg_wdata;
            end
            cfg_ack = (cyc == delay + 1);
            cfg_rdata = rd;
            @(negedge JTCK);
        end
        cfg_ack = 1'b0;
    endtask

    initial begin
        int         cyc;
        logic       we;
        logic [3:0] a;
        logic [7:0] wd;
        logic [13:0] v;
        int         hits;

        // Reset values
        #1 JRSTN = 1'b0;
        @(negedge JTCK);
        @(negedge JTCK);
        chk("rst_req", cfg_req, 0);
        chk("rst_we", cfg_we, 0);
        chk("rst_addr", cfg_addr, 0);
        chk("rst_wdata", cfg_wdata, 0);
        chk("rst_status", status, 0);
        chk("rst_tdo", {JTDO1, JTDO2}, 0);
        JRSTN = 1'b1;
        @(negedge JTCK);

        // WRITE addr 3 data A5, ack after 3 wait cycles
        shift_frame({2'b01, 4'd3, 8'hA5});
        update();
        chk("wr_busy", status, 3'b001);
        slave(3, 8'h00, 400, cyc, we, a, wd);
        chk("wr_cycles", cyc, 4);
        chk("wr_we", we, 1);
        chk("wr_addr", a, 3);
        chk("wr_wdata", wd, 8'hA5);
        chk("wr_done_status", status, 0);

        // READ addr 7 returning 3C, then read back both chains
        shift_frame({2'b10, 4'd7, 8'h00});
        update();
        slave(1, 8'h3C, 400, cyc, we, a, wd);
        chk("rd_cycles", cyc, 2);
        chk("rd_we", we, 0);
        chk("rd_addr", a, 7);
        read_chain(1'b1, 8, v);
        chk("rd_chain2", v[7:0], 8'h3C);
        read_chain(1'b0, 14, v);
        chk("rd_chain1_cap", v, 14'h003C);

        // Three auto-increment writes, zero-wait slave; later addr fields ignored
        shift_frame({2'b11, 4'd15, 8'h11});
        update();
        slave(0, 8'h00, 400, cyc, we, a, wd);
        chk("inc0_cycles", cyc, 1);
        chk("inc0_addr", a, 15);
        shift_frame({2'b11, 4'd5, 8'h22});
        update();
        slave(0, 8'h00, 400, cyc, we, a, wd);
        chk("inc1_addr", a, 0);
        chk("inc1_wdata", wd, 8'h22);
        shift_frame({2'b11, 4'd0, 8'h33});
        update();
        slave(0, 8'h00, 400, cyc, we, a, wd);
        chk("inc2_addr", a, 1);
        chk("inc2_we", we, 1);

        // No ack: timeout after exactly 255 request cycles
        shift_frame({2'b01, 4'd2, 8'h77});
        update();
        slave(1000, 8'h00, 400, cyc, we, a, wd);
        chk("to_cycles", cyc, 255);
        chk("to_status", status, 3'b010);
        JRTI1 = 1'b1;
        @(negedge JTCK);
        JRTI1 = 1'b0;
        chk("to_rti_clear", status, 0);

        // Overrun: second WRITE update while the first is outstanding
        shift_frame({2'b01, 4'd4, 8'h55});
        update();
        shift_frame({2'b01, 4'd9, 8'h99});
        update();
        chk("ovr_status", status, 3'b101);
        chk("ovr_addr_kept", cfg_addr, 4);
        slave(0, 8'h00, 400, cyc, we, a, wd);
        chk("ovr_cycles", cyc, 1);
        chk("ovr_wdata", wd, 8'h55);
        hits = 0;
        for (int i = 0; i < 20; i++) begin
            if (cfg_req === 1'b1) hits++;
            @(negedge JTCK);
        end
        chk("ovr_no_second", hits, 0);
        chk("ovr_status_idle", status, 3'b100);

        // NOP frame leaves flags and state alone; JRTI1 then clears
        shift_frame(14'h0000);
        update();
        chk("nop_req", cfg_req, 0);
        chk("nop_status", status, 3'b100);
        JRTI1 = 1'b1;
        @(negedge JTCK);
        JRTI1 = 1'b0;
        chk("ovr_rti_clear", status, 0);

        // Update after chain 2 was selected is ignored
        shift_frame({2'b01, 4'd6, 8'h66});
        JCE2 = 1'b1;
        @(negedge JTCK);
        JCE2 = 1'b0;
        update();
        chk("sel_req", cfg_req, 0);
        chk("sel_status", status, 0);

        // Reset during WAIT, then a late ack
        shift_frame({2'b10, 4'd1, 8'h00});
        update();
        @(negedge JTCK);
        chk("rw_wait_req", cfg_req, 1);
        #2 JRSTN = 1'b0;
        #1;
        chk("rw_req_now", cfg_req, 0);
        chk("rw_status", status, 0);
        cfg_ack = 1'b1;
        cfg_rdata = 8'hFF;
        @(negedge JTCK);
        JRSTN = 1'b1;
        @(negedge JTCK);
        @(negedge JTCK);
        chk("rw_late_ack_req", cfg_req, 0);
        chk("rw_late_ack_status", status, 0);
        cfg_ack = 1'b0;
        read_chain(1'b1, 8, v);
        chk("rw_rdata", v[7:0], 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
